fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Decoupling buffer between the instruction-fetch unit and the decode stage.
- Holds up to DEPTH fetched {instr, pc} pairs in FIFO order.
- Back-pressures fetch through in_ready; fetch holds its PC while in_ready=0.
- Discards all buffered entries on a branch/jump redirect (clear), so decode never sees wrong-path instructions.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2
- AW, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- clear  input  1  redirect: drop all entries this edge
- in_valid  input  1  fetch presents a valid instruction
- in_instr  input  32  fetched instruction word
- in_pc  input  32  byte address of in_instr (0x3000-based)
- in_ready  output  1  queue can accept a push this cycle
- out_valid  output  1  head entry valid for decode
- out_instr  output  32  head instruction
- out_pc  output  32  head PC
- out_ready  input  1  decode consumes head this cycle (i.e. not stalled)
- count  output  AW+1  current occupancy, 0..DEPTH

Behaviour:
- Storage: DEPTH x 64-bit register array, write pointer wp, read pointer rp, occupancy cnt; pointers wrap modulo DEPTH.
- push = in_valid & in_ready & ~clear.
- pop = out_valid & out_ready & ~clear.
- Priority at each posedge: reset > clear > push/pop.
- reset: wp=rp=cnt=0; array contents need not be cleared.
- Reset-state outputs: out_valid=0, out_instr=0, out_pc=0, in_ready=1, count=0.
- clear: wp=rp=cnt=0 on that edge; the concurrent in_valid word is discarded. Fetch re-fetches from the redirected PC next cycle.
- in_ready = (cnt != DEPTH), combinational from state only. It does not depend on out_ready, so there is no combinational path out_ready->in_ready.
- out_valid = (cnt != 0) & ~clear.
- out_instr/out_pc:
  - When cnt != 0: driven from array[rp].
  - When cnt == 0: forced to 0, a NOP at pc 0.
- Push only: array[wp] <= {in_instr, in_pc}, wp++, cnt++.
- Pop only: rp++, cnt--.
- Push and pop in the same cycle: both pointers advance, cnt unchanged. Legal at any 0 < cnt < DEPTH.
- Full (cnt==DEPTH): in_ready=0, push impossible. A pop that cycle frees one slot, visible as in_ready=1 next cycle.
- Empty (cnt==0): pop impossible. With the optional feature off, an instruction pushed into an empty queue reaches out_valid one cycle later.
- Latency: minimum push-to-out_valid is 1 cycle; throughput is 1 instruction/cycle in steady state.
- count = cnt.
- No X on any output after reset, regardless of array contents.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined: when cnt==0 and in_valid & ~clear:
  - out_valid=1, out_instr=in_instr, out_pc=in_pc combinationally, giving 0-cycle latency.
  - If out_ready=1 the word is consumed directly and not written; wp, rp and cnt are unchanged.
  - If out_ready=0 the word is pushed normally.
- Defined: in_ready is unchanged, and all other cases are as baseline.
- Not defined: baseline behaviour, 1-cycle minimum latency. No combinational path from in_* to out_*.

Test Plan:
- Reset then idle:
  - reset=1 for 2 cycles -> out_valid=0, out_instr=0, out_pc=0, in_ready=1, count=0.
  - No change afterwards with in_valid=0.
- Fill to full, DEPTH=4, out_ready=0:
  - Push pc 0x3000/0x3004/0x3008/0x300c with instrs 0x11111111..0x44444444 -> count=4, in_ready=0.
  - out_pc=0x3000 and out_instr=0x11111111 held.
  - A fifth in_valid is ignored.
- Drain in order:
  - From full, out_ready=1 for 4 cycles -> out_pc sequence 0x3000, 0x3004, 0x3008, 0x300c.
  - Then out_valid=0, count=0.
  - in_ready=1 from the cycle after the first pop.
- Concurrent push/pop at wrap:
  - cnt=2 with rp=3, then push+pop for 6 cycles with pc incrementing by 4 -> count stays 2.
  - Output order is strictly sequential across the pointer wrap.
- Clear mid-stream:
  - cnt=3, assert clear with in_valid=1 (pc 0x3010) -> out_valid=0 during clear, count=0 next cycle.
  - The 0x3010 word never appears.
  - The next push (pc 0x3040) is output first.
- Bypass, macro defined only:
  - Empty queue, in_valid=1, in_pc=0x3000, out_ready=1 -> same cycle out_valid=1, out_pc=0x3000; count stays 0.
  - Same stimulus with out_ready=0 -> count=1 next cycle.

Source files
------------

// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling FIFO of {instr, pc} pairs with redirect flush.
// Optional FETCH_QUEUE_BYPASS_EN: an empty queue forwards the incoming word to decode in the same cycle.
module fetch_queue #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          in_valid,
  input  logic [31:0]   in_instr,
  input  logic [31:0]   in_pc,
  output logic          in_ready,
  output logic          out_valid,
  output logic [31:0]   out_instr,
  output logic [31:0]   out_pc,
  input  logic          out_ready,
  output logic [AW:0]   count
);

  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_ZERO   = (AW + 1)'(0);
  localparam logic [AW:0]   CNT_FULL   = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ZERO   = AW'(0);

  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          empty_s;
  logic          bypass_s;
  logic          push_s;
  logic          pop_s;
  logic [63:0]   head_s;

  assign empty_s  = (cnt_q == CNT_ZERO);
  assign in_ready = (cnt_q != CNT_FULL);
  assign count    = cnt_q;
  assign head_s   = mem_q[rp_q];
  assign pop_s    = ~empty_s & ~clear & out_ready;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass_s = empty_s & in_valid & ~clear;
  // A bypassed word taken by decode this cycle is never written.
  assign push_s   = in_valid & in_ready & ~clear & ~(bypass_s & out_ready);
`else
  assign bypass_s = 1'b0;
  assign push_s   = in_valid & in_ready & ~clear;
`endif

  // Head presentation: stored entry, bypassed input word, or a NOP at pc 0.
  always_comb begin
    out_valid = 1'b0;
    out_instr = 32'd0;
    out_pc    = 32'd0;
    if (!empty_s) begin
      out_valid = ~clear;
      out_instr = head_s[63:32];
      out_pc    = head_s[31:0];
    end else if (bypass_s) begin
      out_valid = 1'b1;
      out_instr = in_instr;
      out_pc    = in_pc;
    end else begin
      out_valid = 1'b0;
      out_instr = 32'd0;
      out_pc    = 32'd0;
    end
  end

  // Pointer and occupancy next-state; clear flushes everything.
  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (clear) begin
      wp_d  = PTR_ZERO;
      rp_d  = PTR_ZERO;
      cnt_d = CNT_ZERO;
    end else begin
      wp_d = push_s ? (wp_q + PTR_ONE) : wp_q;
      rp_d = pop_s  ? (rp_q + PTR_ONE) : rp_q;
      case ({push_s, pop_s})
        2'b10:   cnt_d = cnt_q + CNT_ONE;
        2'b01:   cnt_d = cnt_q - CNT_ONE;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q  <= PTR_ZERO;
      rp_q  <= PTR_ZERO;
      cnt_q <= CNT_ZERO;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      mem_q[wp_q] <= {in_instr, in_pc};
    end
  end

endmodule
